// File: rtl/router_pkg.sv
// Shared router types: FSM encoding, packet byte indices and the checksum rule.
// Used by spi_packet_sender and by the router receiver.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int PKT_BYTES = 3;

  localparam logic [1:0] IDX_DEST  = 2'd0;
  localparam logic [1:0] IDX_DATA  = 2'd1;
  localparam logic [1:0] IDX_CHECK = 2'd2;

  // Widest field the checksum helper supports; callers extend and truncate.
  localparam int CHK_MAX_W = 32;

  function automatic logic [CHK_MAX_W-1:0] calc_check(
    input logic [CHK_MAX_W-1:0] dest,
    input logic [CHK_MAX_W-1:0] data
  );
    return dest ^ data;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 while enabled and pulses tick
// on the terminal count; clear forces the count back to 0.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [7:0] count;

  assign tick = enable && (count == 8'(CLK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/spi_packet_sender.sv
// SPI mode-0 master sending one router packet (dest, data, checksum) per start.
// Optional CORRUPT_CHECK_EN adds force_error, which inverts the sent checksum.
module spi_packet_sender
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef CORRUPT_CHECK_EN
  input  logic              force_error,
`endif
  input  logic [DATA_W-1:0] dest_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              byte_sent,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi
);

  state_t            state;
  state_t            state_next;
  logic              tick;
  logic              sclk_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] check_q;
  logic [DATA_W-1:0] check_calc;
  logic [DATA_W-1:0] check_sel;
  logic [7:0]        bit_cnt;
  logic [1:0]        byte_idx;
  logic              accept;
  logic              last_bit;

  // The done cycle is already IDLE, so it is excluded from accepting a new start.
  assign accept     = (state == IDLE) && start && !done;
  assign last_bit   = (state == SHIFT) && tick && sclk_q && (bit_cnt == 8'(DATA_W - 1));
  assign check_calc = DATA_W'(calc_check(CHK_MAX_W'(dest_in), CHK_MAX_W'(data_in)));

`ifdef CORRUPT_CHECK_EN
  assign check_sel = force_error ? ~check_calc : check_calc;
`else
  assign check_sel = check_calc;
`endif

  spi_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .clock (clock),
    .reset (reset),
    .clear (state_next != state),
    .enable(state != IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = SETUP;
      SETUP:   if (tick)     state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = (byte_idx == IDX_CHECK) ? HOLD : GAP;
      GAP:     if (tick)     state_next = SHIFT;
      HOLD:    if (tick)     state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Falling SCLK edges shift the next bit; the 8th one loads the following byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_q    <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      check_q   <= '0;
      bit_cnt   <= '0;
      byte_idx  <= IDX_DEST;
      done      <= 1'b0;
      byte_sent <= 1'b0;
    end else begin
      done      <= (state == HOLD) && tick;
      byte_sent <= last_bit;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_q  <= dest_in;
            data_q   <= data_in;
            check_q  <= check_sel;
            byte_idx <= IDX_DEST;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              if (last_bit) begin
                bit_cnt <= '0;
                if (byte_idx != IDX_CHECK) begin
                  shift_q  <= (byte_idx == IDX_DEST) ? data_q : check_q;
                  byte_idx <= byte_idx + 2'd1;
                end
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    spi_cs_n = (state == IDLE);
    spi_sclk = sclk_q;
    spi_mosi = (state != IDLE) ? shift_q[DATA_W-1] : 1'b0;
  end

endmodule

// File: tb/tb_spi_packet_sender.sv
// Randomised bench for spi_packet_sender: an SPI slave monitor rebuilds bytes on
// SCLK rising edges and a packet-level model predicts bytes, timing and routing.
module tb_spi_packet_sender;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 2;
  localparam int FRAME_CYCLES = 52 * CLK_DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dest_in = 8'h00;
  logic [7:0] data_in = 8'h00;
`ifdef CORRUPT_CHECK_EN
  logic       force_error = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic       byte_sent;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;

  spi_packet_sender #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
`ifdef CORRUPT_CHECK_EN
    .force_error(force_error),
`endif
    .dest_in  (dest_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .byte_sent(byte_sent),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int accept_cyc = 0;

  // Slave-side observation of the link
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = 8'h00;
  int         nbits = 0;
  int         rise_cnt = 0;
  int         bs_cnt = 0;
  int         done_cnt = 0;
  int         mosi_viol = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;

  // Packet the model expects on the wire
  logic [7:0] exp_dest = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] exp_chk  = 8'h00;

  always @(negedge clock) begin
    if (spi_cs_n) begin
      nbits = 0;
    end else if (spi_sclk && !prev_sclk) begin
      rise_cnt++;
      if (spi_mosi !== prev_mosi) mosi_viol++;
      rx_sh = {rx_sh[6:0], spi_mosi};
      nbits++;
      if (nbits == 8) begin
        rx_q.push_back(rx_sh);
        nbits = 0;
      end
    end
    if (byte_sent) bs_cnt++;
    if (done) done_cnt++;
    prev_sclk = spi_sclk;
    prev_mosi = spi_mosi;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic clearModel();
    rx_q.delete();
    rise_cnt  = 0;
    bs_cnt    = 0;
    done_cnt  = 0;
    mosi_viol = 0;
  endtask

  task automatic setExpected(input logic [7:0] d, input logic [7:0] p, input logic fe);
    exp_dest = d;
    exp_data = p;
    exp_chk  = fe ? ~(d ^ p) : (d ^ p);
  endtask

  task automatic scrambleInputs();
    dest_in = 8'($urandom);
    data_in = 8'($urandom);
`ifdef CORRUPT_CHECK_EN
    force_error = 1'($urandom);
`endif
  endtask

  task automatic launchFrame(input logic [7:0] d, input logic [7:0] p, input logic fe);
    setExpected(d, p, fe);
    @(negedge clock);
    dest_in = d;
    data_in = p;
`ifdef CORRUPT_CHECK_EN
    force_error = fe;
`endif
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    accept_cyc = cyc;
    scrambleInputs();
    checkOutput("busy_on_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic waitDone(input int retrig, output int lat);
    int waited = 0;
    while (!done && waited < 60 * CLK_DIV) begin
      @(negedge clock);
      waited++;
      start = (retrig >= 0 && waited == retrig);
    end
    start = 1'b0;
    lat = done ? (cyc - accept_cyc) : -1;
  endtask

  task automatic checkFrame();
    checkOutput("rx_byte_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      checkOutput("rx_dest", {24'd0, rx_q[0]}, {24'd0, exp_dest});
      checkOutput("rx_data", {24'd0, rx_q[1]}, {24'd0, exp_data});
      checkOutput("rx_check", {24'd0, rx_q[2]}, {24'd0, exp_chk});
    end
    checkOutput("sclk_rises", rise_cnt, 24);
    checkOutput("byte_sent_pulses", bs_cnt, 3);
    checkOutput("mosi_stable_on_rise", mosi_viol, 0);
  endtask

  // Router receiver view: checksum decides error, dest bit 0 picks the port.
  task automatic routerCheck(input logic [7:0] d, input logic fe);
    logic err;
    logic [1:0] ports;
    if (rx_q.size() == 3) begin
      err   = (rx_q[2] != (rx_q[0] ^ rx_q[1]));
      ports = err ? 2'b00 : (rx_q[0][0] ? 2'b01 : 2'b10);
      checkOutput("router_error_flag", {31'd0, err}, {31'd0, fe});
      checkOutput("router_port_enables", {30'd0, ports},
                  {30'd0, (fe ? 2'b00 : (d[0] ? 2'b01 : 2'b10))});
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] p, input logic fe, input int retrig);
    int lat;
    clearModel();
    launchFrame(d, p, fe);
    waitDone(retrig, lat);
    checkOutput("done_latency", lat, FRAME_CYCLES);
    checkFrame();
    routerCheck(d, fe);
    repeat (30 * CLK_DIV) @(negedge clock);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("idle_after_frame", {29'd0, busy, spi_cs_n, spi_sclk}, 32'b010);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;

    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", {26'd0, spi_cs_n, spi_sclk, spi_mosi, busy, done, byte_sent}, 32'b100000);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checkOutput("idle_outputs", {26'd0, spi_cs_n, spi_sclk, spi_mosi, busy, done, byte_sent}, 32'b100000);
    end

    applyStimulus(8'h01, 8'hA5, 1'b0, -1);
    applyStimulus(8'h00, 8'h3C, 1'b0, -1);
    applyStimulus(8'h01, 8'h3C, 1'b0, -1);
    applyStimulus(8'h5A, 8'hC3, 1'b0, 30);

    for (int i = 0; i < 6; i++) begin
`ifdef CORRUPT_CHECK_EN
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), -1);
`else
      applyStimulus(8'($urandom), 8'($urandom), 1'b0, -1);
`endif
    end

    // Start held through the done cycle is only taken one cycle later
    clearModel();
    launchFrame(8'h11, 8'h22, 1'b0);
    waitDone(-1, lat);
    checkOutput("b2b_first_latency", lat, FRAME_CYCLES);
    checkFrame();
    dest_in = 8'h33;
    data_in = 8'h44;
`ifdef CORRUPT_CHECK_EN
    force_error = 1'b0;
`endif
    start = 1'b1;
    @(negedge clock);
    checkOutput("start_on_done_ignored", {30'd0, spi_cs_n, busy}, 32'b10);
    clearModel();
    setExpected(8'h33, 8'h44, 1'b0);
    @(negedge clock);
    start = 1'b0;
    accept_cyc = cyc;
    scrambleInputs();
    checkOutput("b2b_second_accepted", {30'd0, spi_cs_n, busy}, 32'b01);
    waitDone(-1, lat);
    checkOutput("b2b_second_latency", lat, FRAME_CYCLES);
    checkFrame();
    repeat (5) @(negedge clock);

    // Reset in the middle of byte 1, bit 4 rising half
    clearModel();
    launchFrame(8'h01, 8'hA5, 1'b0);
    repeat (54) @(negedge clock);
    checkOutput("pre_reset_sclk", {31'd0, spi_sclk}, 32'd1);
    checkOutput("pre_reset_bytes", rx_q.size(), 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_async_outputs", {29'd0, spi_cs_n, spi_sclk, busy}, 32'b100);
    done_cnt = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("no_done_after_reset", done_cnt, 0);
    checkOutput("idle_after_reset", {29'd0, spi_cs_n, spi_sclk, busy}, 32'b100);
    applyStimulus(8'h7E, 8'h81, 1'b0, -1);

`ifdef CORRUPT_CHECK_EN
    applyStimulus(8'h01, 8'hA5, 1'b1, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
